// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game judge.
package tank_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAY       = 2'd1,
    ROUND_OVER = 2'd2,
    GAME_OVER  = 2'd3
  } judge_state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P0   = 2'b01,
    P1   = 2'b10,
    DRAW = 2'b11
  } winner_t;

  localparam logic [3:0] WIN_SCORE_DEFAULT     = 4'd5;
  localparam logic [7:0] FREEZE_FRAMES_DEFAULT = 8'd60;
  localparam logic [9:0] TANK_SIZE_DEFAULT     = 10'd32;
  localparam logic [9:0] BULLET_SIZE_DEFAULT   = 10'd8;

  localparam logic [1:0] BULL_FLY    = 2'b01;
  localparam logic [1:0] BULL_CANCEL = 2'b00;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Inclusive axis-aligned box overlap test; end coordinates are widened so
// boxes near the right/bottom edge of the 10-bit space never wrap.
module box_overlap (
  input  logic [9:0] a_x,
  input  logic [9:0] a_y,
  input  logic [9:0] a_size,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] b_size,
  output logic       hit
);

  logic [10:0] a_x_end, a_y_end, b_x_end, b_y_end;

  assign a_x_end = {1'b0, a_x} + {1'b0, a_size};
  assign a_y_end = {1'b0, a_y} + {1'b0, a_size};
  assign b_x_end = {1'b0, b_x} + {1'b0, b_size};
  assign b_y_end = {1'b0, b_y} + {1'b0, b_size};

  assign hit = ({1'b0, a_x} <= b_x_end) && ({1'b0, b_x} <= a_x_end) &&
               ({1'b0, a_y} <= b_y_end) && ({1'b0, b_y} <= a_y_end);

endmodule

// File: rtl/bullet_judge.sv
// Bullet/tank hit judge with score keeping and round/game sequencing.
// Define BULLET_CLASH_EN to let two in-flight bullets cancel each other.
//
// state      | meaning
// IDLE       | waiting for start, tanks frozen
// PLAY       | round in progress, hits evaluated each frame
// ROUND_OVER | someone scored, tanks frozen for FREEZE_FRAMES frames
// GAME_OVER  | a player reached WIN_SCORE, winner held until start
module bullet_judge
  import tank_pkg::*;
#(
  parameter logic [3:0] WIN_SCORE     = WIN_SCORE_DEFAULT,
  parameter logic [7:0] FREEZE_FRAMES = FREEZE_FRAMES_DEFAULT,
  parameter logic [9:0] TANK_SIZE     = TANK_SIZE_DEFAULT,
  parameter logic [9:0] BULLET_SIZE   = BULLET_SIZE_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic [1:0] p0_hit,
  input  logic [1:0] p1_hit,
  input  logic [9:0] p0_bullet_X,
  input  logic [9:0] p0_bullet_Y,
  input  logic [9:0] p1_bullet_X,
  input  logic [9:0] p1_bullet_Y,
  input  logic [9:0] p0_tank_X,
  input  logic [9:0] p0_tank_Y,
  input  logic [9:0] p1_tank_X,
  input  logic [9:0] p1_tank_Y,
  output logic [1:0] p0_bull_hit,
  output logic [1:0] p1_bull_hit,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       freeze,
  output logic       round_reset,
  output logic       game_over,
  output logic [1:0] winner
);

  judge_state_t state;
  logic       frame_clk_d, tick;
  logic [7:0] frame_cnt;
  logic       cancel0, cancel1;
  logic       ov0, ov1, clash;
  logic       hit0, hit1;
  logic       keep0, keep1, set0, set1;
  logic [3:0] s0_next, s1_next;
  logic       win0, win1;

  box_overlap u_p0_on_p1 (
    .a_x(p0_bullet_X), .a_y(p0_bullet_Y), .a_size(BULLET_SIZE),
    .b_x(p1_tank_X),   .b_y(p1_tank_Y),   .b_size(TANK_SIZE),
    .hit(ov0)
  );

  box_overlap u_p1_on_p0 (
    .a_x(p1_bullet_X), .a_y(p1_bullet_Y), .a_size(BULLET_SIZE),
    .b_x(p0_tank_X),   .b_y(p0_tank_Y),   .b_size(TANK_SIZE),
    .hit(ov1)
  );

`ifdef BULLET_CLASH_EN
  logic ov_bb;

  box_overlap u_clash (
    .a_x(p0_bullet_X), .a_y(p0_bullet_Y), .a_size(BULLET_SIZE),
    .b_x(p1_bullet_X), .b_y(p1_bullet_Y), .b_size(BULLET_SIZE),
    .hit(ov_bb)
  );

  assign clash = (p0_hit == BULL_FLY) && (p1_hit == BULL_FLY) && ov_bb;
`else
  assign clash = 1'b0;
`endif

  assign hit0 = (p0_hit == BULL_FLY) && ov0;
  assign hit1 = (p1_hit == BULL_FLY) && ov1;

  // A cancelled bullet stays cancelled until its controller reports it retired.
  assign keep0 = cancel0 & ~(tick & (p0_hit == BULL_CANCEL));
  assign keep1 = cancel1 & ~(tick & (p1_hit == BULL_CANCEL));
  assign set0  = hit0 | clash | keep0;
  assign set1  = hit1 | clash | keep1;

  assign s0_next = hit0 ? sat_inc(score0) : score0;
  assign s1_next = hit1 ? sat_inc(score1) : score1;
  assign win0    = (s0_next >= WIN_SCORE);
  assign win1    = (s1_next >= WIN_SCORE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_d <= 1'b0;
      tick        <= 1'b0;
    end else begin
      frame_clk_d <= frame_clk;
      tick        <= frame_clk & ~frame_clk_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      score0      <= 4'd0;
      score1      <= 4'd0;
      p0_bull_hit <= BULL_CANCEL;
      p1_bull_hit <= BULL_CANCEL;
      freeze      <= 1'b1;
      round_reset <= 1'b0;
      game_over   <= 1'b0;
      winner      <= NONE;
      frame_cnt   <= 8'd0;
      cancel0     <= 1'b0;
      cancel1     <= 1'b0;
    end else begin
      round_reset <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          cancel0 <= keep0;
          cancel1 <= keep1;
          if (start) begin
            state       <= PLAY;
            score0      <= 4'd0;
            score1      <= 4'd0;
            round_reset <= 1'b1;
            freeze      <= 1'b0;
            game_over   <= 1'b0;
            winner      <= NONE;
            cancel0     <= 1'b0;
            cancel1     <= 1'b0;
            p0_bull_hit <= BULL_FLY;
            p1_bull_hit <= BULL_FLY;
          end
        end

        PLAY: begin
          if (tick) begin
            score0  <= s0_next;
            score1  <= s1_next;
            cancel0 <= set0;
            cancel1 <= set1;
            if (win0 || win1) begin
              state       <= GAME_OVER;
              freeze      <= 1'b1;
              game_over   <= 1'b1;
              winner      <= (win0 && win1) ? DRAW : (win0 ? P0 : P1);
              p0_bull_hit <= BULL_CANCEL;
              p1_bull_hit <= BULL_CANCEL;
            end else if (hit0 || hit1) begin
              state       <= ROUND_OVER;
              frame_cnt   <= 8'd0;
              freeze      <= 1'b1;
              p0_bull_hit <= BULL_CANCEL;
              p1_bull_hit <= BULL_CANCEL;
            end else begin
              p0_bull_hit <= set0 ? BULL_CANCEL : BULL_FLY;
              p1_bull_hit <= set1 ? BULL_CANCEL : BULL_FLY;
            end
          end
        end

        ROUND_OVER: begin
          cancel0 <= keep0;
          cancel1 <= keep1;
          if (tick) begin
            if (frame_cnt == FREEZE_FRAMES - 8'd1) begin
              state       <= PLAY;
              round_reset <= 1'b1;
              freeze      <= 1'b0;
              p0_bull_hit <= keep0 ? BULL_CANCEL : BULL_FLY;
              p1_bull_hit <= keep1 ? BULL_CANCEL : BULL_FLY;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
